// File: rtl/fixed_point_accumulator.sv
// Q16.16 product accumulator: sums LEN products into one result with a sticky overflow flag.
// Optional feature: define FXP_ACC_SATURATE_EN to clamp the running sum on add overflow instead of wrapping.
module fixed_point_accumulator #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    // Reject configurations the datapath cannot represent.
    if (DATA_W != 32 || FRAC_W < 0 || FRAC_W >= DATA_W || LEN < 1 || LEN > 65535) begin : g_param_check
        $error("fixed_point_accumulator: illegal DATA_W/FRAC_W/LEN");
    end

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   acc_r;
    logic                ovf_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W:0]     sum_s;
    logic                add_ovf_s;
    logic [DATA_W-1:0]   acc_next_s;
    logic                accept_s;
    logic                last_s;

    // Sign-extended addition with signed overflow detect on the top two sum bits.
    function automatic logic [DATA_W:0] add_ext(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        add_ext = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    endfunction

    // Accumulate datapath: sum, overflow detect and wrap/saturate selection.
    always_comb begin
        sum_s      = add_ext(acc_r, in_data);
        add_ovf_s  = sum_s[DATA_W] ^ sum_s[DATA_W-1];
        acc_next_s = sum_s[DATA_W-1:0];
`ifdef FXP_ACC_SATURATE_EN
        if (add_ovf_s) begin
            if (sum_s[DATA_W]) begin
                acc_next_s = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                acc_next_s = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            acc_next_s = sum_s[DATA_W-1:0];
        end
`else
        acc_next_s = sum_s[DATA_W-1:0];
`endif
        accept_s = in_valid && (state_r == ST_ACC);
        last_s   = (cnt_r == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: leave ACC on the last beat, leave HOLD on the output handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_ACC: begin
                if (accept_s && last_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_s = ST_ACC;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_ACC;
        endcase
    end

    // Handshake outputs decode only the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_ACC: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ST_HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Accumulator, sticky overflow and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {DATA_W{1'b0}};
            ovf_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (in_valid) begin
                        acc_r <= acc_next_s;
                        ovf_r <= ovf_r | in_ovf | add_ovf_s;
                        if (last_s) begin
                            cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        acc_r <= acc_r;
                        ovf_r <= ovf_r;
                        cnt_r <= cnt_r;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc_r <= {DATA_W{1'b0}};
                        ovf_r <= 1'b0;
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        acc_r <= acc_r;
                        ovf_r <= ovf_r;
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    acc_r <= {DATA_W{1'b0}};
                    ovf_r <= 1'b0;
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign out_data = acc_r;
    assign out_ovf  = ovf_r;

endmodule
